// File: rtl/ifu_fetch_if.sv
// Fetch unit bundle: PC-stage hand-off, memory request/response port and decode handshake.
// master = fetch unit side, slave = PC stage / memory / decode side.
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_current;
    logic            pc_advance;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            mem_resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;
    logic [31:0]     fetch_count;

    modport master (
        input  pc_current, mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err, inst_ready,
        output pc_advance, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_fault,
               fetch_count
    );

    modport slave (
        output pc_current, mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err, inst_ready,
        input  pc_advance, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_fault,
               fetch_count
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding fetch at the current PC, result held for decode,
// PC register advanced by a one-cycle pulse on the decode handshake.
module ifu_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] FAULT_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus_io
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_fault_q, inst_fault_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            pc_aligned;
    logic            advance;

    assign pc_aligned = (bus_io.pc_current[1:0] == 2'b00);
    assign advance    = (state_q == HOLD) && bus_io.inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            inst_q        <= FAULT_INST;
            inst_pc_q     <= '0;
            inst_fault_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            if (advance) begin
                fetch_count_q <= fetch_count_d;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_fault_d  = inst_fault_q;
        fetch_count_d = fetch_count_q + 32'd1;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                inst_pc_d = bus_io.pc_current;
                // A misaligned PC never reaches memory; it is reported as a fault directly.
                if (!pc_aligned) begin
                    inst_d       = FAULT_INST;
                    inst_fault_d = 1'b1;
                    state_d      = HOLD;
                end else if (bus_io.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus_io.mem_resp_valid) begin
                    inst_d       = bus_io.mem_resp_err ? FAULT_INST : bus_io.mem_resp_data;
                    inst_fault_d = bus_io.mem_resp_err;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (bus_io.inst_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_io.mem_req_valid = 1'b0;
        bus_io.mem_req_addr  = '0;
        bus_io.inst_valid    = 1'b0;
        bus_io.pc_advance    = 1'b0;
        case (state_q)
            REQ: begin
                bus_io.mem_req_valid = pc_aligned;
                bus_io.mem_req_addr  = bus_io.pc_current;
            end
            HOLD: begin
                bus_io.inst_valid = 1'b1;
                bus_io.pc_advance = advance;
            end
            default: ;
        endcase
    end

    assign bus_io.inst        = inst_q;
    assign bus_io.inst_pc     = inst_pc_q;
    assign bus_io.inst_fault  = inst_fault_q;
    assign bus_io.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: PC stage, memory and decode models around the DUT, with a scoreboard
// of expected instructions derived from each PC handed to the fetch unit.
module tb_ifu_fetch;
    localparam logic [31:0] FAULT = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(32)) bus();
    ifu_fetch #(.XLEN(32), .FAULT_INST(FAULT)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    int          errors = 0;
    int          checks = 0;
    int          n_retired = 0;
    logic [31:0] exp_count = 0;
    exp_t        exp_q[$];
    logic [31:0] pc_plan[$];
    int          req_pct = 100, inst_pct = 100, min_d = 0, max_d = 0, stray_pct = 0;
    bit          mem_pending = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents and bus-error map, shared by the memory model and the reference model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0297;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic bus_err(input logic [31:0] a);
        return a[4:2] == 3'd5;
    endfunction

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        if (pc[1:0] != 2'b00 || bus_err(pc)) e = '{FAULT, pc, 1'b1};
        else                                  e = '{mem_word(pc), pc, 1'b0};
        return e;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] a;
        a = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic set_pc(input logic [31:0] a);
        bus.pc_current = a;
        exp_q.push_back(model(a));
    endtask

    task automatic wait_inst(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.inst_valid && n < 50);
        if (!bus.inst_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: inst_valid not seen within 50 cycles", nm);
        end
    endtask

    // PC stage, memory and decode drivers: sample at negedge, drive just after posedge.
    initial begin : driver
        bit          s_acc, s_resp, s_adv;
        logic [31:0] s_addr;
        logic [31:0] paddr;
        int          delay;
        paddr = '0;
        delay = 0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        forever begin
            @(negedge clk);
            s_acc  = bus.mem_req_valid & bus.mem_req_ready;
            s_addr = bus.mem_req_addr;
            s_resp = bus.mem_resp_valid & mem_pending;
            s_adv  = bus.pc_advance;
            @(posedge clk);
            #1;
            if (s_resp) mem_pending = 0;
            if (s_acc) begin
                mem_pending = 1;
                paddr       = s_addr;
                delay       = $urandom_range(min_d, max_d);
            end
            if (rst) mem_pending = 0;
            if (mem_pending) begin
                if (delay == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = mem_word(paddr);
                    bus.mem_resp_err   = bus_err(paddr);
                end else begin
                    delay--;
                    bus.mem_resp_valid = 1'b0;
                end
            end else if ($urandom_range(0, 99) < stray_pct) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 32'hDEAD_BEEF;
                bus.mem_resp_err   = 1'($urandom_range(0, 1));
            end else begin
                bus.mem_resp_valid = 1'b0;
            end
            if (s_adv && !rst) set_pc(pc_plan.size() != 0 ? pc_plan.pop_front() : rand_pc());
            bus.mem_req_ready = ($urandom_range(0, 99) < req_pct);
            bus.inst_ready    = ($urandom_range(0, 99) < inst_pct);
        end
    end

    initial begin : monitor
        logic        pq, pqr, pv, pr;
        logic [31:0] paddr;
        exp_t        pin, cur, e;
        pq = 0; pqr = 0; pv = 0; pr = 0; paddr = '0; pin = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pq = 0;
                pv = 0;
                continue;
            end
            cur = '{bus.inst, bus.inst_pc, bus.inst_fault};
            if (pq && !pqr) begin
                chk("req_held_valid", 32'(bus.mem_req_valid), 32'd1);
                chk("req_held_addr", bus.mem_req_addr, paddr);
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(bus.inst_valid), 32'd1);
                chk("hold_inst", cur.inst, pin.inst);
                chk("hold_pc", cur.pc, pin.pc);
                chk("hold_fault", 32'(cur.fault), 32'(pin.fault));
            end
            if (bus.mem_req_valid) chk("req_aligned", 32'(bus.mem_req_addr[1:0]), 32'd0);
            chk("pc_advance", 32'(bus.pc_advance), 32'(bus.inst_valid & bus.inst_ready));
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: handshake pc %h with nothing expected", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst", cur.inst, e.inst);
                    chk("sb_pc", cur.pc, e.pc);
                    chk("sb_fault", 32'(cur.fault), 32'(e.fault));
                    chk("sb_count", bus.fetch_count, exp_count);
                    exp_count++;
                    n_retired++;
                end
            end
            pq = bus.mem_req_valid; pqr = bus.mem_req_ready; paddr = bus.mem_req_addr;
            pv = bus.inst_valid;    pr = bus.inst_ready;     pin = cur;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   n;
        int   target;
        exp_t hold;
        pc_plan = '{32'h8000_0004, 32'h8000_0008, 32'h8000_0002,
                    32'h8000_0014, 32'h8000_000C, 32'h8000_0010};
        set_pc(32'h8000_0000);
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_req_addr", bus.mem_req_addr, 32'd0);
        chk("rst_pc_advance", 32'(bus.pc_advance), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, FAULT);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_fault", 32'(bus.inst_fault), 32'd0);
        chk("rst_count", bus.fetch_count, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // First fetch: request one cycle after release, instruction two cycles later.
        @(negedge clk); chk("first_idle", 32'(bus.mem_req_valid), 32'd0);
        @(negedge clk); chk("first_req", 32'(bus.mem_req_valid), 32'd1);
        chk("first_addr", bus.mem_req_addr, 32'h8000_0000);
        @(negedge clk); chk("first_wait", 32'(bus.inst_valid), 32'd0);
        @(negedge clk); chk("first_valid", 32'(bus.inst_valid), 32'd1);
        chk("first_inst", bus.inst, 32'h0000_0297);
        chk("first_pc", bus.inst_pc, 32'h8000_0000);
        chk("first_fault", 32'(bus.inst_fault), 32'd0);
        chk("first_adv", 32'(bus.pc_advance), 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pc_advance && n < 20);
        chk("throughput_gap", 32'(n), 32'd3);

        // Request backpressure: three cycles with ready low, accepted on the fourth.
        req_pct = 0;
        @(negedge clk); chk("stall_c1_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("stall_c1_addr", bus.mem_req_addr, 32'h8000_0008);
        repeat (2) @(negedge clk);
        chk("stall_c3_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("stall_c3_addr", bus.mem_req_addr, 32'h8000_0008);
        req_pct = 100;
        @(negedge clk); chk("stall_c4_valid", 32'(bus.mem_req_valid), 32'd1);
        inst_pct = 0;
        @(negedge clk); chk("accepted_drop", 32'(bus.mem_req_valid), 32'd0);

        // Decode backpressure: five HOLD cycles, then a single pulse.
        @(negedge clk); chk("hold_h1", 32'(bus.inst_valid), 32'd1);
        hold = '{bus.inst, bus.inst_pc, bus.inst_fault};
        repeat (4) @(negedge clk);
        chk("hold_h5_adv", 32'(bus.pc_advance), 32'd0);
        chk("hold_h5_inst", bus.inst, hold.inst);
        chk("hold_h5_pc", bus.inst_pc, hold.pc);
        inst_pct = 100;
        @(negedge clk); chk("hold_release_adv", 32'(bus.pc_advance), 32'd1);
        chk("hold_release_pc", bus.inst_pc, 32'h8000_0008);
        @(negedge clk); chk("single_pulse", 32'(bus.pc_advance), 32'd0);
        chk("mis_no_req", 32'(bus.mem_req_valid), 32'd0);
        @(negedge clk); chk("mis_valid", 32'(bus.inst_valid), 32'd1);
        chk("mis_fault", 32'(bus.inst_fault), 32'd1);
        chk("mis_inst", bus.inst, FAULT);
        chk("mis_pc", bus.inst_pc, 32'h8000_0002);

        wait_inst("err_fetch");
        chk("err_fault", 32'(bus.inst_fault), 32'd1);
        chk("err_inst", bus.inst, FAULT);
        chk("err_pc", bus.inst_pc, 32'h8000_0014);
        chk("err_adv", 32'(bus.pc_advance), 32'd1);

        // Reset while a response is still outstanding.
        min_d = 3; max_d = 3;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_pending && n < 20);
        chk("pre_rst_wait_req", 32'(bus.mem_req_valid), 32'd0);
        chk("pre_rst_wait_inst", 32'(bus.inst_valid), 32'd0);
        #2; rst = 1'b1;
        exp_count = 0;
        stray_pct = 100;
        #1;
        chk("async_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("async_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("async_inst", bus.inst, FAULT);
        chk("async_inst_pc", bus.inst_pc, 32'd0);
        chk("async_count", bus.fetch_count, 32'd0);
        min_d = 0; max_d = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk); chk("restart_idle", 32'(bus.mem_req_valid), 32'd0);
        chk("restart_no_inst", 32'(bus.inst_valid), 32'd0);
        @(negedge clk); chk("restart_req", 32'(bus.mem_req_valid), 32'd1);
        chk("restart_addr", bus.mem_req_addr, 32'h8000_000C);
        stray_pct = 0;
        wait_inst("restart_fetch");
        chk("restart_inst", bus.inst, mem_word(32'h8000_000C));
        chk("restart_pc", bus.inst_pc, 32'h8000_000C);

        // Counter wrap.
        inst_pct = 0;
        wait_inst("wrap_hold");
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.fetch_count_q;
        chk("preload_count", bus.fetch_count, 32'hFFFF_FFFF);
        inst_pct = 100;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pc_advance && n < 20);
        @(negedge clk); chk("count_wrapped", bus.fetch_count, 32'd0);

        // Randomized traffic with backpressure, variable latency and stray responses.
        req_pct = 70; inst_pct = 70; min_d = 0; max_d = 3; stray_pct = 20;
        target = n_retired + 150;
        n = 0;
        while (n_retired < target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n_retired < target) begin
            checks++;
            errors++;
            $display("FAIL random_progress: retired %0d of %0d", n_retired, target);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
